// File: rtl/cpu_mem_pkg.sv
// Shared types for the IF/MEM memory port arbiter:
// FSM states, grant owner and wait-counter width.
package cpu_mem_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter for the extra RAM access cycles.
// zero marks the final ACCESS cycle of a transfer.
module mem_wait_counter
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WCNT_W-1:0] value,
  input  logic              dec,
  output logic              zero
);

  logic [WCNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stages onto one single-port RAM (MEM first).
// Define MEM_ARB_PERF_EN to add stall / MEM-transfer counters.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_mem_cnt
`endif
);

  localparam logic [WCNT_W-1:0] LP_WAIT = WCNT_W'(WAIT_CYCLES);

  arb_state_t r_state;
  gnt_t       r_gnt;
  logic       w_zero;
  logic       w_load;
  logic       w_dec;
  logic       w_done;

  assign w_load = (r_state == S_IDLE) && (mem_req || if_req);
  assign w_dec  = (r_state == S_ACCESS) && !w_zero;
  assign w_done = (r_state == S_ACCESS) && w_zero;

  mem_wait_counter u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (LP_WAIT),
    .dec   (w_dec),
    .zero  (w_zero)
  );

  assign stall = (mem_req & ~mem_ready) | (if_req & ~if_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= GNT_IF;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_gnt     <= GNT_MEM;
            ram_addr  <= mem_addr;
            ram_we    <= mem_we;
            ram_wdata <= mem_wdata;
            ram_en    <= 1'b1;
            r_state   <= S_ACCESS;
          end else if (if_req) begin
            r_gnt    <= GNT_IF;
            ram_addr <= if_addr;
            ram_we   <= 1'b0;
            ram_en   <= 1'b1;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_zero) begin
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            r_state <= S_RESP;
            if (r_gnt == GNT_MEM) begin
              mem_ready <= 1'b1;
              // stores leave the last load result in place
              if (!ram_we) mem_rdata <= ram_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_mem_cnt   <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (w_done && (r_gnt == GNT_MEM))
        perf_mem_cnt <= perf_mem_cnt + 32'd1;
    end
  end
`endif

endmodule
